// File: rtl/ts_record_ctrl_if.sv
// TS byte-stream bundle used by ts_record_ctrl.
//   TS_VALID_IN/TS_SYNC_IN/TS_DATA_IN    : stream from the TS input stage
//   TS_VALID_OUT/TS_SYNC_OUT/TS_DATA_OUT : stream to the TS output stage
// Modports:
//   master : the surrounding datapath (drives *_IN, receives *_OUT)
//   slave  : the record/replay controller (receives *_IN, drives *_OUT)
interface ts_record_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              TS_VALID_IN;
  logic              TS_SYNC_IN;
  logic [DATA_W-1:0] TS_DATA_IN;
  logic              TS_VALID_OUT;
  logic              TS_SYNC_OUT;
  logic [DATA_W-1:0] TS_DATA_OUT;

  modport master (
    output TS_VALID_IN, TS_SYNC_IN, TS_DATA_IN,
    input  TS_VALID_OUT, TS_SYNC_OUT, TS_DATA_OUT
  );

  modport slave (
    input  TS_VALID_IN, TS_SYNC_IN, TS_DATA_IN,
    output TS_VALID_OUT, TS_SYNC_OUT, TS_DATA_OUT
  );
endinterface

// File: rtl/ts_record_ctrl.sv
// MPEG-TS record/replay controller.
// Passes the TS stream through (1-cycle registered), records whole packets into an internal
// {sync, data} buffer, and replays them once or in a loop. Mode changes land on packet bounds.
// Ports:
//   CLOCK, RESET          : system clock, synchronous active-high reset
//   PASS, PLAY, REC       : mode requests
//   LOOP                  : replay wraps when set at the end of the buffer
//   ts (slave)            : TS input/output byte streams
//   STATE                 : 0 passthrough, 1 record armed, 2 recording, 3 replay
//   REC_LEN               : bytes in the last complete recording
//   FULL                  : sticky, recording stopped on buffer exhaustion
//   SYNC_ERR              : one-cycle pulse on a premature sync while recording
module ts_record_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned PKT_LEN = 188
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            PASS,
  input  logic            PLAY,
  input  logic            REC,
  input  logic            LOOP,
  ts_record_ctrl_if.slave ts,
  output logic [1:0]      STATE,
  output logic [ADDR_W:0] REC_LEN,
  output logic            FULL,
  output logic            SYNC_ERR
);
  localparam int unsigned CntW = $clog2(PKT_LEN);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [CntW-1:0]   PktLast  = CntW'(PKT_LEN - 1);

  typedef enum logic [1:0] {StPass = 2'd0, StArm = 2'd1, StRec = 2'd2, StPlay = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   last_end_q, last_end_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic [CntW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic              full_q, full_d;
  logic              sync_err_q, sync_err_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic              stop_q, stop_d;
  logic              rd_vld_q;
  logic [DATA_W:0]   rd_word_q;
  logic              out_valid_q, out_valid_d;
  logic              out_sync_q, out_sync_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              rd_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic              premature;
  logic [ADDR_W-1:0] wr_tgt;
  logic              sel_replay;

  logic [DATA_W:0]   mem [2**ADDR_W];

  // A sync inside a packet rewinds the write pointer to the last complete packet boundary.
  assign premature = ts.TS_VALID_IN & ts.TS_SYNC_IN & (pkt_cnt_q != '0);
  assign wr_tgt    = premature ? last_end_q[ADDR_W-1:0] : wr_addr_q;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    last_end_d = last_end_q;
    rec_len_d  = rec_len_q;
    pkt_cnt_d  = pkt_cnt_q;
    full_d     = full_q;
    sync_err_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    stop_d     = stop_q;
    rd_en      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr_q;

    unique case (state_q)
      StPass: begin
        if (REC) begin
          rec_len_d = '0;
          full_d    = 1'b0;
          state_d   = StArm;
        end else if (PLAY && (rec_len_q != '0)) begin
          rd_addr_d = '0;
          rd_cnt_d  = '0;
          stop_d    = 1'b0;
          state_d   = StPlay;
        end
      end

      StArm: begin
        if (PASS) begin
          rec_len_d = '0;
          state_d   = StPass;
        end else if (ts.TS_VALID_IN && ts.TS_SYNC_IN) begin
          mem_we     = 1'b1;
          mem_waddr  = '0;
          wr_addr_d  = AddrOne;
          pkt_cnt_d  = CntOne;
          last_end_d = '0;
          state_d    = StRec;
        end
      end

      StRec: begin
        if (PASS) begin
          // Partial packet is dropped; a coincident exhaustion still raises FULL.
          rec_len_d = last_end_q;
          state_d   = StPass;
          if (ts.TS_VALID_IN && (wr_tgt == LastAddr)) full_d = 1'b1;
        end else if (ts.TS_VALID_IN) begin
          mem_we    = 1'b1;
          mem_waddr = wr_tgt;
          if (premature) begin
            sync_err_d = 1'b1;
            pkt_cnt_d  = CntOne;
          end else if (pkt_cnt_q == PktLast) begin
            pkt_cnt_d  = '0;
            last_end_d = {1'b0, wr_addr_q} + LenOne;
          end else begin
            pkt_cnt_d  = pkt_cnt_q + CntOne;
          end
          wr_addr_d = wr_tgt + AddrOne;
          if (wr_tgt == LastAddr) begin
            full_d    = 1'b1;
            rec_len_d = last_end_d;
            state_d   = StPass;
          end
        end
      end

      StPlay: begin
        rd_en    = 1'b1;
        stop_d   = stop_q | PASS;
        rd_cnt_d = (rd_cnt_q == PktLast) ? '0 : rd_cnt_q + CntOne;
        if ((rd_cnt_q == PktLast) && (stop_q || PASS)) begin
          state_d = StPass;
        end else if ({1'b0, rd_addr_q} == rec_len_q - LenOne) begin
          if (LOOP) rd_addr_d = '0;
          else      state_d   = StPass;
        end else begin
          rd_addr_d = rd_addr_q + AddrOne;
        end
      end
    endcase
  end

  // The output register follows the read pipeline while replay is starting, running, or
  // draining its last word; otherwise it is a plain registered copy of the input.
  assign sel_replay = (state_d == StPlay) | rd_vld_q;

  always_comb begin
    if (sel_replay) begin
      out_valid_d = rd_vld_q;
      out_sync_d  = rd_vld_q & rd_word_q[DATA_W];
      out_data_d  = rd_vld_q ? rd_word_q[DATA_W-1:0] : '0;
    end else begin
      out_valid_d = ts.TS_VALID_IN;
      out_sync_d  = ts.TS_SYNC_IN;
      out_data_d  = ts.TS_DATA_IN;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= StPass;
      wr_addr_q   <= '0;
      last_end_q  <= '0;
      rec_len_q   <= '0;
      pkt_cnt_q   <= '0;
      full_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      stop_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      last_end_q  <= last_end_d;
      rec_len_q   <= rec_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
      full_q      <= full_d;
      sync_err_q  <= sync_err_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      stop_q      <= stop_d;
      rd_vld_q    <= rd_en;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      out_data_q  <= out_data_d;
    end
  end

  // Buffer storage: no reset, synchronous read.
  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[mem_waddr] <= {ts.TS_SYNC_IN, ts.TS_DATA_IN};
    rd_word_q <= mem[rd_addr_q];
  end

  assign STATE           = state_q;
  assign REC_LEN         = rec_len_q;
  assign FULL            = full_q;
  assign SYNC_ERR        = sync_err_q;
  assign ts.TS_VALID_OUT = out_valid_q;
  assign ts.TS_SYNC_OUT  = out_sync_q;
  assign ts.TS_DATA_OUT  = out_data_q;
endmodule
